mul_iter: RTL

Iterative shift-add 32×32→64 multiplier, signed or unsigned, the multiplicative counterpart of the trial-subtraction divider. It sits beside the divider in the EX stage. It uses the same start/annul/ready handshake, so the EX stall and forwarding logic can drive either unit identically. It serves madd/msub-style multi-cycle multiply paths where a single-cycle 32×32 array is too costly.

---
 rtl/mul_iter_if.sv | 22 ++
 rtl/mul_iter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mul_iter_if.sv
// Handshake and operand bundle shared by mul_iter and whatever drives it from EX.
interface mul_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic               signed_mul_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_mul_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (WIDTH x WIDTH -> 2*WIDTH), signed or unsigned.
// Works on operand magnitudes for a fixed WIDTH iterations, then applies the
// product sign in one extra cycle. Start/annul/ready handshake matches the divider.
module mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  mul_iter_if.slave bus
);

  localparam int unsigned ResW = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  localparam logic [1:0] StFree = 2'd0;
  localparam logic [1:0] StZero = 2'd1;
  localparam logic [1:0] StOn   = 2'd2;
  localparam logic [1:0] StEnd  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [ResW-1:0]  acc_q, acc_d;
  logic [ResW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             signed_q, signed_d;
  logic             sign1_q, sign1_d;
  logic             sign2_q, sign2_d;
  logic [ResW-1:0]  result_q, result_d;
  logic             ready_q, ready_d;

  logic             op_sign1, op_sign2;
  logic [WIDTH-1:0] mag1, mag2;

  // Operand signs and magnitudes; the most negative value maps to itself read as unsigned.
  always_comb begin
    op_sign1 = bus.opdata1_i[WIDTH-1] & bus.signed_mul_i;
    op_sign2 = bus.opdata2_i[WIDTH-1] & bus.signed_mul_i;
    mag1     = op_sign1 ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
    mag2     = op_sign2 ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
  end

  // Next-state logic for the control FSM and datapath.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    signed_d = signed_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    result_d = result_q;
    ready_d  = ready_q;

    unique case (state_q)
      StFree: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          signed_d = bus.signed_mul_i;
          sign1_d  = op_sign1;
          sign2_d  = op_sign2;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, mag1};
          mplier_d = mag2;
          state_d  = ((mag1 == '0) || (mag2 == '0)) ? StZero : StOn;
        end
      end

      StZero: begin
        // Zero product needs no sign correction.
        acc_d   = '0;
        state_d = StEnd;
      end

      StOn: begin
        if (bus.annul_i) begin
          state_d = StFree;
        end else if (cnt_q == CntW'(WIDTH)) begin
          if (signed_q && (sign1_q ^ sign2_q)) begin
            acc_d = ~acc_q + ResW'(1);
          end
          cnt_d   = '0;
          state_d = StEnd;
        end else begin
          // Fixed iteration count: no early exit when the multiplier runs out of ones.
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end

      StEnd: begin
        if (!bus.start_i) begin
          state_d  = StFree;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          ready_d  = 1'b1;
          result_d = acc_q;
        end
      end

      default: state_d = StFree;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFree;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      signed_q <= 1'b0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      signed_q <= signed_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule
